data_mem_ctrl: RTL and testbench

Downstream neighbour of the CPU core; consumes its data-memory request bus (enable, write-enable, word address, write data) and returns read data. Decodes a word-addressed map into a synchronous data RAM and a small MMIO bank: LEDs, switches, cycle counter, and a buffered console output port. The console port drains through a FIFO with a valid/ready handshake to an external sink.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/con_fifo.sv | 61 ++++++
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: MMIO map, register offsets and the
// console status word layout.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [2:0] OFF_LED      = 3'd0;
    localparam logic [2:0] OFF_SW       = 3'd1;
    localparam logic [2:0] OFF_CYCLE    = 3'd2;
    localparam logic [2:0] OFF_CON_DATA = 3'd3;
    localparam logic [2:0] OFF_CON_STAT = 3'd4;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_COUNT_LSB = 2;
    localparam int unsigned STAT_COUNT_MSB = 4;
    localparam int unsigned STAT_OVF       = 5;

    typedef enum logic [1:0] {
        RegionRam,
        RegionMmio,
        RegionUnmapped
    } region_e;

    function automatic logic [31:0] con_stat_word(input logic       full,
                                                  input logic       empty,
                                                  input logic [2:0] count,
                                                  input logic       ovf);
        logic [31:0] w;
        w = '0;
        w[STAT_FULL] = full;
        w[STAT_EMPTY] = empty;
        w[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        w[STAT_OVF] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/con_fifo.sv
// Parameterised synchronous FIFO with occupancy count and sticky overflow flag.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module con_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_q;
    logic             ovf_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign head     = empty ? '0 : mem[rd_ptr];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: decodes CPU word addresses into a synchronous RAM and an MMIO bank
// (LEDs, switches, cycle counter, buffered console output).
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SW_SYNC    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [15:0] led,
    input  logic [15:0] sw,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        bus_err
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    region_e       region;
    logic [2:0]    offset;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   ram [2**AW];
    logic [15:0]   sw_sync [SW_SYNC];
    logic [31:0]   cycle_cnt;
    logic [31:0]   mmio_rdata;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic [CW-1:0] fifo_count;

    assign offset = addr[2:0];
    assign wr_en  = mem_en && mem_wen;
    assign rd_en  = mem_en && !mem_wen;

    always_comb begin
        region = RegionUnmapped;
        if (!addr[31] && addr[30:AW] == '0) begin
            region = RegionRam;
        end else if (addr[31] && addr[30:3] == '0) begin
            region = RegionMmio;
        end
    end

    // Offsets 5-7 are mapped but empty: they read as zero without raising bus_err.
    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_LED:      mmio_rdata = {16'h0, led};
            OFF_SW:       mmio_rdata = {16'h0, sw_sync[SW_SYNC-1]};
            OFF_CYCLE:    mmio_rdata = cycle_cnt;
            OFF_CON_STAT: mmio_rdata = con_stat_word(fifo_full, fifo_empty, 3'(fifo_count),
                                                     fifo_ovf);
            default:      mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && region == RegionRam) begin
            ram[addr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SW_SYNC; i++) sw_sync[i] <= '0;
        end else begin
            sw_sync[0] <= sw;
            for (int i = 1; i < SW_SYNC; i++) sw_sync[i] <= sw_sync[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata     <= '0;
            rvalid    <= 1'b0;
            led       <= '0;
            bus_err   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            rvalid    <= rd_en;
            if (rd_en) begin
                case (region)
                    RegionRam:  rdata <= ram[addr[AW-1:0]];
                    RegionMmio: rdata <= mmio_rdata;
                    default:    rdata <= '0;
                endcase
            end
            if (wr_en && region == RegionMmio && offset == OFF_LED) begin
                led <= wdata[15:0];
            end
            if (mem_en && region == RegionUnmapped) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign fifo_push = wr_en && region == RegionMmio && offset == OFF_CON_DATA;
    assign con_valid = !fifo_empty;

    con_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_con_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(wdata[7:0]),
        .pop      (con_valid && con_ready),
        .head     (con_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model of the memory map.
module tb_data_mem_ctrl;
    localparam int unsigned AW         = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned SW_SYNC    = 2;
    localparam logic [31:0] MMIO       = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [15:0] led;
    logic [15:0] sw = '0;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .AW        (AW),
        .FIFO_DEPTH(FIFO_DEPTH),
        .SW_SYNC   (SW_SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_en   (mem_en),
        .mem_wen  (mem_wen),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .led      (led),
        .sw       (sw),
        .con_data (con_data),
        .con_valid(con_valid),
        .con_ready(con_ready),
        .bus_err  (bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [0:1023];
    logic [7:0]  m_q [$];
    logic [15:0] m_swq [$];
    logic [15:0] m_led;
    logic [31:0] m_cycle;
    logic        m_ovf;
    logic        m_berr;
    logic [31:0] e_rdata;
    logic        e_rvalid;
    logic        m_full;
    logic        m_pop;
    logic        m_push;
    logic        m_mapped;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned n;
        n = m_q.size();
        if (a < 32'(2**AW)) return m_ram[a[9:0]];
        if (a >= MMIO && a < MMIO + 8) begin
            case (a - MMIO)
                32'd0: return {16'h0, m_led};
                32'd1: return {16'h0, m_swq[0]};
                32'd2: return m_cycle;
                32'd4: return 32'(m_ovf) * 32 + n * 4 + 32'(n == 0) * 2
                              + 32'(n == FIFO_DEPTH);
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_swq.delete();
            for (int i = 0; i < SW_SYNC; i++) m_swq.push_back(16'h0);
            m_led = '0;
            m_cycle = '0;
            m_ovf = 1'b0;
            m_berr = 1'b0;
            e_rdata = '0;
            e_rvalid = 1'b0;
        end else begin
            m_full = (m_q.size() == FIFO_DEPTH);
            m_pop = (m_q.size() != 0) && con_ready;
            m_mapped = (addr < 32'(2**AW)) || (addr >= MMIO && addr < MMIO + 8);
            m_push = 1'b0;
            e_rvalid = mem_en && !mem_wen;
            if (mem_en && !mem_wen) e_rdata = model_read(addr);
            if (mem_en && !m_mapped) m_berr = 1'b1;
            if (mem_en && mem_wen) begin
                if (addr < 32'(2**AW)) m_ram[addr[9:0]] = wdata;
                else if (addr == MMIO) m_led = wdata[15:0];
                else if (addr == MMIO + 3) m_push = 1'b1;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (!m_full || m_pop) m_q.push_back(wdata[7:0]);
                else m_ovf = 1'b1;
            end
            m_swq.push_back(sw);
            void'(m_swq.pop_front());
            m_cycle = m_cycle + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rvalid", 32'(rvalid), 32'(e_rvalid));
            check("rdata", rdata, e_rdata);
            check("led", 32'(led), 32'(m_led));
            check("bus_err", 32'(bus_err), 32'(m_berr));
            check("con_valid", 32'(con_valid), 32'(m_q.size() != 0));
            check("con_data", 32'(con_data), (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
        end
    end

    logic [7:0] sink [$];
    always @(posedge clk) begin
        if (!reset && con_valid && con_ready) sink.push_back(con_data);
    end

    // ---------------- stimulus ----------------
    task automatic bus_op(input logic wen, input logic [31:0] a, input logic [31:0] d);
        mem_en = 1'b1;
        mem_wen = wen;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        mem_wen = 1'b0;
    endtask

    task automatic check_sink(input string name, input int idx, input logic [7:0] exp);
        check(name, (sink.size() > idx) ? {24'h0, sink[idx]} : 32'hFFFF_FFFF, {24'h0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1;
        logic [7:0]  abcd [4];
        logic [7:0]  nums [5];
        abcd = '{8'h41, 8'h42, 8'h43, 8'h44};
        nums = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h5A};

        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_con_valid", 32'(con_valid), 32'h0);
        check("reset_bus_err", 32'(bus_err), 32'h0);
        #2 reset = 1'b0;

        // RAM write then read back, data held afterwards
        bus_op(1'b1, 32'd5, 32'hDEAD_BEEF);
        bus_op(1'b0, 32'd5, 32'h0);
        check("ram_rvalid", 32'(rvalid), 32'h1);
        check("ram_rdata", rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("ram_rvalid_drop", 32'(rvalid), 32'h0);
        check("ram_rdata_hold", rdata, 32'hDEAD_BEEF);

        // LED and switches
        bus_op(1'b1, MMIO, 32'h0001_A5A5);
        check("led_value", 32'(led), 32'h0000_A5A5);
        bus_op(1'b0, MMIO, 32'h0);
        check("led_readback", rdata, 32'h0000_A5A5);
        sw = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        bus_op(1'b0, MMIO + 1, 32'h0);
        check("sw_readback", rdata, 32'h0000_1234);

        // cycle counter spacing
        bus_op(1'b0, MMIO + 2, 32'h0);
        r1 = rdata;
        repeat (3) @(posedge clk);
        #1;
        bus_op(1'b0, MMIO + 2, 32'h0);
        check("cycle_diff", rdata - r1, 32'd4);

        // console overflow with sink stalled
        con_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_op(1'b1, MMIO + 3, 32'h41 + 32'(i));
        bus_op(1'b0, MMIO + 4, 32'h0);
        check("stat_full_ovf", rdata, 32'h0000_0031);
        check("con_head_a", 32'(con_data), 32'h41);
        sink.delete();
        con_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_count", sink.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_sink("drain_order", i, abcd[i]);
        check("drain_con_valid", 32'(con_valid), 32'h0);
        bus_op(1'b0, MMIO + 4, 32'h0);
        check("stat_empty_bit", 32'(rdata[1]), 32'h1);

        // push into full FIFO with a simultaneous pop
        con_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_op(1'b1, MMIO + 3, 32'h31 + 32'(i));
        sink.delete();
        con_ready = 1'b1;
        bus_op(1'b1, MMIO + 3, 32'h5A);
        bus_op(1'b0, MMIO + 4, 32'h0);
        check("stat_push_pop_full", rdata, 32'h0000_0031);
        repeat (8) @(posedge clk);
        #1;
        check("z_count", sink.size(), 32'd5);
        for (int i = 0; i < 5; i++) check_sink("z_order", i, nums[i]);

        // unmapped access
        bus_op(1'b0, 32'h0000_1000, 32'h0);
        check("unmapped_rvalid", 32'(rvalid), 32'h1);
        check("unmapped_rdata", rdata, 32'h0);
        check("unmapped_bus_err", 32'(bus_err), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("bus_err_sticky", 32'(bus_err), 32'h1);

        // reset in the middle of a drain with a read pending
        con_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_op(1'b1, MMIO + 3, 32'h78 + 32'(i));
        con_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        mem_wen = 1'b0;
        addr = 32'd5;
        #2 reset = 1'b1;
        #1;
        check("rst_con_valid", 32'(con_valid), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rvalid_held", 32'(rvalid), 32'h0);
        #1 reset = 1'b0;

        // random traffic
        for (int i = 0; i < 16; i++) bus_op(1'b1, 32'(i), $urandom);
        for (int i = 0; i < 1500; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            con_ready = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            mem_en = 1'b1;
            mem_wen = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if (sel < 30) begin
                addr = 32'($urandom_range(0, 15));
            end else if (sel < 50) begin
                addr = MMIO + 3;
                mem_wen = 1'b1;
            end else if (sel < 88) begin
                addr = MMIO + 32'($urandom_range(0, 7));
            end else if (sel < 91) begin
                case ($urandom_range(0, 2))
                    0: addr = 32'h0000_0400 + 32'($urandom_range(0, 1023));
                    1: addr = MMIO + 8 + 32'($urandom_range(0, 255));
                    default: addr = 32'h4000_0000;
                endcase
            end else begin
                mem_en = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        mem_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
